// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters in the top level are enabled with HAZARD_PERF_EN.
package hazard_pkg;

    typedef logic [0:0] hz_state_t;

    localparam hz_state_t RUN      = 1'b0;
    localparam hz_state_t MEM_WAIT = 1'b1;

    localparam int         MEM_TIMEOUT_DEFAULT = 16;
    localparam logic [4:0] REG_X0              = 5'h00;

    // Load in E whose destination feeds a source of the instruction in D; x0 never hazards.
    function automatic logic load_use_hit(
        input logic [4:0] rd_e,
        input logic [4:0] rs1_d,
        input logic [4:0] rs2_d,
        input logic       mem_read_e
    );
        return mem_read_e && (rd_e != REG_X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Data-memory wait-state machine: freezes the pipeline while an access is pending,
// forcing release after MEM_TIMEOUT stalled cycles and latching a sticky error.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | no access outstanding, wait_cnt = 0
// MEM_WAIT | access in M stalled; wait_cnt = stalled cycles so far
module mem_wait_timer
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_req,
    input  logic mem_ready,
    output logic mem_stall,
    output logic mem_err
);

    localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             pending;
    logic             timeout_hit;

    always_comb begin
        pending     = mem_req & ~mem_ready;
        mem_stall   = pending & (wait_cnt_q < CNT_LIMIT);
        timeout_hit = pending & (wait_cnt_q == CNT_LIMIT);
    end

    // Any cycle without a stall (ready, timeout or withdrawn request) ends the wait.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | timeout_hit;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush generation for the 5-stage RV32 pipeline (load-use, taken branch, memory wait).
// Define HAZARD_PERF_EN to add the StallCount/FlushCount performance counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1_D,
    input  logic [4:0]  Rs2_D,
    input  logic [4:0]  RD_E,
    input  logic        MemReadE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    logic mem_stall_raw;
    logic mem_stall;
    logic lw_stall;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (MemReqM),
        .mem_ready (MemReadyM),
        .mem_stall (mem_stall_raw),
        .mem_err   (MemErr)
    );

    // A taken branch flushes D anyway, so it masks the load-use stall.
    always_comb begin
        mem_stall = mem_stall_raw & ~reset;
        lw_stall  = load_use_hit(RD_E, Rs1_D, Rs2_D, MemReadE) & ~PCSrcE;
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            StallF = 1'b0;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q + 32'(StallF);
        flush_count_d = flush_count_q + 32'(FlushE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit built with MEM_TIMEOUT = 4.
// Counter checks are active when HAZARD_PERF_EN is defined.
module tb_hazard_control_unit;

    localparam int TIMEOUT = 4;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1_D, Rs2_D, RD_E;
    logic       MemReadE, PCSrcE, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCount, FlushCount;
`endif

    int checks = 0;
    int errors = 0;
    int model_stall_cnt = 0;
    int model_flush_cnt = 0;

    // expected output bundle order: StallF StallD StallE StallM FlushD FlushE FlushW
    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b1100010;
    localparam logic [6:0] O_BR    = 7'b0000110;
    localparam logic [6:0] O_MWAIT = 7'b1111001;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mr;
        logic       pc;
        logic       rq;
        logic       rdy;
        logic [6:0] exp_o;
        logic       exp_err;
    } vec_t;

    vec_t vecs[12];

    hazard_control_unit #(
        .MEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Rs1_D     (Rs1_D),
        .Rs2_D     (Rs2_D),
        .RD_E      (RD_E),
        .MemReadE  (MemReadE),
        .PCSrcE    (PCSrcE),
        .MemReqM   (MemReqM),
        .MemReadyM (MemReadyM),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushW    (FlushW),
        .MemErr    (MemErr)
`ifdef HAZARD_PERF_EN
        ,
        .StallCount (StallCount),
        .FlushCount (FlushCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive at the falling edge, check just after, model the counters.
    task automatic step(input string name, input logic rst,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic pc, input logic rq, input logic rdy,
                        input logic [6:0] exp_o, input logic exp_err);
        logic [6:0] got;
        @(negedge clk);
        reset     = rst;
        Rs1_D     = rs1;
        Rs2_D     = rs2;
        RD_E      = rd;
        MemReadE  = mr;
        PCSrcE    = pc;
        MemReqM   = rq;
        MemReadyM = rdy;
        #1;
        got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL %s: controls got %b expected %b", name, got, exp_o);
        end
        checks++;
        if (MemErr !== exp_err) begin
            errors++;
            $display("FAIL %s: MemErr got %b expected %b", name, MemErr, exp_err);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (StallCount !== 32'(model_stall_cnt)) begin
            errors++;
            $display("FAIL %s: StallCount got %0d expected %0d", name, StallCount, model_stall_cnt);
        end
        checks++;
        if (FlushCount !== 32'(model_flush_cnt)) begin
            errors++;
            $display("FAIL %s: FlushCount got %0d expected %0d", name, FlushCount, model_flush_cnt);
        end
`endif
        if (rst) begin
            model_stall_cnt = 0;
            model_flush_cnt = 0;
        end else begin
            model_stall_cnt += int'(exp_o[6]);
            model_flush_cnt += int'(exp_o[1]);
        end
    endtask

    task automatic idle(input string name, input logic exp_err);
        step(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, exp_err);
    endtask

    initial begin
        reset = 1'b1;
        Rs1_D = '0; Rs2_D = '0; RD_E = '0;
        MemReadE = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;

        //          name              rs1   rs2   rd    mr    pc    rq    rdy   exp      err
        vecs[0]  = '{"idle",          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE,  1'b0};
        vecs[1]  = '{"lu_rs2",        5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,    1'b0};
        vecs[2]  = '{"lu_rs1",        5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,    1'b0};
        vecs[3]  = '{"x0_dest",       5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE,  1'b0};
        vecs[4]  = '{"load_nomatch",  5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE,  1'b0};
        vecs[5]  = '{"match_noload",  5'd5, 5'd9, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE,  1'b0};
        vecs[6]  = '{"branch",        5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,    1'b0};
        vecs[7]  = '{"branch_lu",     5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,    1'b0};
        vecs[8]  = '{"lu_mem_ready",  5'd8, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, O_LU,    1'b0};
        vecs[9]  = '{"mwait_over_all",5'd8, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, O_MWAIT, 1'b0};
        vecs[10] = '{"withdraw_br",   5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR,    1'b0};
        vecs[11] = '{"idle_after",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE,  1'b0};

        step("reset", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 1'b0);

        for (int i = 0; i < 12; i++)
            step(vecs[i].name, 1'b0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr,
                 vecs[i].pc, vecs[i].rq, vecs[i].rdy, vecs[i].exp_o, vecs[i].exp_err);

        // load-use stalls exactly one cycle, then the load has moved to M
        step("lu_seq_stall", 1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, 1'b0);
        step("lu_seq_moved", 1'b0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, 1'b0);

        // memory wait of 3 cycles, released on the 4th
        for (int i = 0; i < 3; i++)
            step("mwait_stall", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_MWAIT, 1'b0);
        step("mwait_release", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, 1'b0);
        idle("mwait_no_err", 1'b0);

        // timeout: 4 stalled cycles, forced release on the 5th, sticky error afterwards
        for (int i = 0; i < TIMEOUT; i++)
            step("tmo_stall", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_MWAIT, 1'b0);
        step("tmo_release", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_NONE, 1'b0);
        step("tmo_fresh_wait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_MWAIT, 1'b1);
        step("tmo_fresh_done", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, 1'b1);
        idle("tmo_err_sticky1", 1'b1);
        step("tmo_err_sticky2", 1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, O_LU, 1'b1);

        // reset in the second cycle of a wait
        step("rst_wait_c1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_MWAIT, 1'b1);
        step("rst_wait_c2", 1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, O_NONE, 1'b1);
        idle("rst_after", 1'b0);
        for (int i = 0; i < TIMEOUT; i++)
            step("rst_new_stall", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_MWAIT, 1'b0);
        step("rst_new_release", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_NONE, 1'b0);
        idle("rst_new_err", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage RV32 core. Generates per-stage stall and flush controls for load-use hazards, taken branches/jumps, and multi-cycle data-memory accesses, working alongside the EX-stage forwarding unit. A wait-state machine freezes the pipeline while data memory is busy, with a bounded timeout and a sticky error flag.

## Interface
- MEM_TIMEOUT, 16: maximum stalled cycles per memory access before forced release. Must be ≥1.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs1_D, Rs2_D  in  5 each  source registers of the instruction in Decode.
- RD_E  in  5  destination register of the instruction in Execute.
- MemReadE  in  1  instruction in Execute is a load.
- PCSrcE  in  1  branch/jump taken in Execute.
- MemReqM  in  1  instruction in Memory accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register or PC.
- FlushD, FlushE, FlushW  out  1 each  insert a bubble into the D, E or W register.
- MemErr  out  1  sticky memory-timeout flag.
- StallCount, FlushCount  out  32 each  performance counters; present only with HAZARD_PERF_EN.

## Operation
- FSM states: RUN and MEM_WAIT. A wait counter wait_cnt, $clog2(MEM_TIMEOUT+1) bits wide, is 0 in RUN.
- memStall = MemReqM & !MemReadyM & (wait_cnt < MEM_TIMEOUT).
- timeoutHit = MemReqM & !MemReadyM & (wait_cnt == MEM_TIMEOUT).
- lwStall = MemReadE & (RD_E != 0) & (RD_E == Rs1_D | RD_E == Rs2_D) & !PCSrcE.
  - A taken branch suppresses lwStall because the D instruction is flushed anyway.
- Priority is reset, then memStall, then branch, then lwStall.
- When memStall is high:
  - StallF = StallD = StallE = StallM = 1 and FlushW = 1.
  - FlushD = FlushE = 0. lwStall and PCSrcE are ignored; they are re-evaluated once the pipeline moves.
- When memStall is low:
  - StallF = StallD = lwStall.
  - StallE = StallM = FlushW = 0.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- FSM transitions:
  - RUN to MEM_WAIT on memStall; wait_cnt goes to 1.
  - MEM_WAIT stays on memStall; wait_cnt increments.
  - MEM_WAIT to RUN on MemReadyM or timeoutHit; wait_cnt goes to 0.
- timeoutHit sets MemErr on the next edge. The access then proceeds unstalled with undefined data.
- MemErr is cleared only by reset.
- A new access arriving in M right after release starts a fresh wait with wait_cnt = 0.

## Timing
- Stall and flush outputs are combinational from inputs and current state, valid in the same cycle. There is no added latency.
- A load-use hazard gives exactly 1 stall cycle: the load advances to M and the hazard clears.
- A memory wait stalls N cycles, where N is the number of cycles with MemReadyM low, capped at MEM_TIMEOUT.
- The cycle in which MemReadyM = 1 is unstalled.
- While reset = 1:
  - All Stall* and Flush* outputs are 0.
  - On the edge: state = RUN, wait_cnt = 0, MemErr = 0, counters = 0.
- Reset asserted in MEM_WAIT aborts the wait immediately.
- MemReqM falling without MemReadyM (access withdrawn) returns the FSM to RUN with wait_cnt = 0 and no error.

## Configuration
- HAZARD_PERF_EN defined: adds StallCount and FlushCount.
  - StallCount increments on every cycle with StallF = 1.
  - FlushCount increments on every cycle with FlushE = 1.
  - Both are 32-bit and wrap modulo 2^32.
- HAZARD_PERF_EN undefined: the ports and registers are absent. Remaining behaviour is identical.

## Structure
- hazard_pkg holds the state typedef (RUN, MEM_WAIT), the MEM_TIMEOUT default and the x0 constant 5'h00.
- One sub-module, mem_wait_timer, holds the FSM, wait_cnt, timeoutHit and MemErr.
- Top level: hazard-equation logic plus the optional counters.

## Test plan
- **Load-use hazard:** RD_E = 5, MemReadE = 1, Rs2_D = 5, PCSrcE = 0 → StallF = StallD = FlushE = 1 for 1 cycle; StallCount = 1.
- **x0 destination:** RD_E = 0, MemReadE = 1, Rs1_D = 0 → no stall and no flush.
- **Branch with load-use:** PCSrcE = 1 together with a load-use match → FlushD = FlushE = 1 and StallF = 0.
- **Memory wait:** MemReqM = 1, MemReadyM low for 3 cycles then high → StallF..StallM and FlushW = 1 for exactly 3 cycles; released on the 4th; MemErr = 0.
- **Timeout:** MEM_TIMEOUT = 4, MemReadyM held low → 4 stall cycles, release on the 5th, MemErr = 1 from the next edge and held until reset.
- **Reset mid-wait:** reset = 1 in cycle 2 of a wait → outputs 0 immediately; after release, FSM in RUN, MemErr = 0, counters = 0.
